// File: rtl/census_pkg.sv
// census_pkg -- shared constants for the 3x3 census transform.
//
// Contents:
//   CENSUS_WIDTH   width of a census code (one bit per neighbour)
//   WIN_SIZE       side length of the square window
//   COORD_W        width of the row/column counters and coordinate outputs
//   BIT_*          bit position of each neighbour inside a census code
//   coord_t        row/column coordinate type
package census_pkg;

  localparam int CENSUS_WIDTH = 8;
  localparam int WIN_SIZE     = 3;
  localparam int COORD_W      = 11;

  // Neighbour positions inside the census code, raster order around the centre.
  localparam int BIT_TL = 7;
  localparam int BIT_T  = 6;
  localparam int BIT_TR = 5;
  localparam int BIT_L  = 4;
  localparam int BIT_R  = 3;
  localparam int BIT_BL = 2;
  localparam int BIT_B  = 1;
  localparam int BIT_BR = 0;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/census_line_buffer.sv
// census_line_buffer -- one line of pixel delay.
//
// Each write cycle reads the word stored at addr (written one line earlier)
// and overwrites it with wr_data, so rd_data is wr_data delayed by DEPTH
// accepted pixels. Contents are not reset: the consumer ignores the output
// until the buffer has been filled by the current frame.
//
// Ports:
//   clk      rising-edge clock
//   wr_en    write strobe (one per accepted pixel)
//   addr     column address, read and write share it
//   wr_data  pixel entering the delay line
//   rd_data  pixel leaving the delay line (combinational read of addr)
module census_line_buffer #(
  parameter int DEPTH  = 640,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign rd_data = mem_q[addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/census_transform.sv
// census_transform -- streaming 3x3 census transform over a raster image.
//
// Pixels arrive in raster order, one per cycle where valid_in is high. Two
// line buffers supply rows r-1 and r-2 for the current column, and a 3x3
// window register shifts in one column per accepted pixel. When the window
// holds a full 3x3 neighbourhood of the current frame (pixel at row>=2,
// col>=2) the census code of the window centre is registered and
// valid_out strobes one cycle after that pixel.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   pixel_in    raster-order pixel
//   valid_in    pixel_in accepted on each clk edge where high
//   sof_in      with valid_in: this pixel is row 0, col 0
//   census_out  registered census code (bit 7 = top-left ... bit 0 = bottom-right)
//   valid_out   one-cycle strobe per census_out
//   census_row  centre row of census_out     (only with CENSUS_COORD_EN)
//   census_col  centre column of census_out  (only with CENSUS_COORD_EN)
//
// Build option: define CENSUS_COORD_EN to add the coordinate outputs.
module census_transform
  import census_pkg::*;
#(
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int PIXEL_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PIXEL_WIDTH-1:0]  pixel_in,
  input  logic                    valid_in,
  input  logic                    sof_in,
  output logic [CENSUS_WIDTH-1:0] census_out,
  output logic                    valid_out
`ifdef CENSUS_COORD_EN
  ,
  output logic [COORD_W-1:0]      census_row,
  output logic [COORD_W-1:0]      census_col
`endif
);

  localparam int     LB_AW      = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam coord_t COL_LAST   = coord_t'(IMG_WIDTH - 1);
  localparam coord_t ROW_LAST   = coord_t'(IMG_HEIGHT - 1);
  localparam coord_t FIRST_FULL = coord_t'(WIN_SIZE - 1);

  coord_t col_q, col_d, row_q, row_d;
  coord_t col_eff, row_eff;

  // win_q[row][col]: row 0 = top (r-2), col 2 = newest column.
  logic [PIXEL_WIDTH-1:0] win_q [WIN_SIZE][WIN_SIZE];
  logic [PIXEL_WIDTH-1:0] win_d [WIN_SIZE][WIN_SIZE];

  logic [PIXEL_WIDTH-1:0]  lb1_rd, lb2_rd, centre;
  logic [CENSUS_WIDTH-1:0] code, census_q, census_d;
  logic                    valid_q, valid_d, win_full;

  // sof_in overrides the counters so the pixel is placed at (0,0).
  always_comb begin
    col_eff = sof_in ? '0 : col_q;
    row_eff = sof_in ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (valid_in) begin
      if (col_eff == COL_LAST) begin
        col_d = '0;
        row_d = (row_eff == ROW_LAST) ? '0 : row_eff + coord_t'(1);
      end else begin
        col_d = col_eff + coord_t'(1);
        row_d = row_eff;
      end
    end
  end

  census_line_buffer #(
    .DEPTH  (IMG_WIDTH),
    .DATA_W (PIXEL_WIDTH),
    .ADDR_W (LB_AW)
  ) u_lb_r1 (
    .clk     (clk),
    .wr_en   (valid_in),
    .addr    (col_eff[LB_AW-1:0]),
    .wr_data (pixel_in),
    .rd_data (lb1_rd)
  );

  census_line_buffer #(
    .DEPTH  (IMG_WIDTH),
    .DATA_W (PIXEL_WIDTH),
    .ADDR_W (LB_AW)
  ) u_lb_r2 (
    .clk     (clk),
    .wr_en   (valid_in),
    .addr    (col_eff[LB_AW-1:0]),
    .wr_data (lb1_rd),
    .rd_data (lb2_rd)
  );

  // Shift the window left by one column and load the new column on the right.
  always_comb begin
    win_d = win_q;
    if (valid_in) begin
      for (int r = 0; r < WIN_SIZE; r++) begin
        for (int c = 0; c < WIN_SIZE - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      win_d[0][WIN_SIZE-1] = lb2_rd;
      win_d[1][WIN_SIZE-1] = lb1_rd;
      win_d[2][WIN_SIZE-1] = pixel_in;
    end
  end

  // Code is taken from the window as it will be after this pixel, which
  // gives the fixed one-cycle latency from pixel to registered code.
  always_comb begin
    centre       = win_d[1][1];
    code         = '0;
    code[BIT_TL] = win_d[0][0] < centre;
    code[BIT_T]  = win_d[0][1] < centre;
    code[BIT_TR] = win_d[0][2] < centre;
    code[BIT_L]  = win_d[1][0] < centre;
    code[BIT_R]  = win_d[1][2] < centre;
    code[BIT_BL] = win_d[2][0] < centre;
    code[BIT_B]  = win_d[2][1] < centre;
    code[BIT_BR] = win_d[2][2] < centre;
  end

  // Requiring col>=2 also keeps previous-line columns out of the window.
  always_comb begin
    win_full = valid_in && (row_eff >= FIRST_FULL) && (col_eff >= FIRST_FULL);
    census_d = win_full ? code : census_q;
    valid_d  = win_full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q    <= '0;
      row_q    <= '0;
      census_q <= '0;
      valid_q  <= 1'b0;
      for (int r = 0; r < WIN_SIZE; r++) begin
        for (int c = 0; c < WIN_SIZE; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      census_q <= census_d;
      valid_q  <= valid_d;
      win_q    <= win_d;
    end
  end

  assign census_out = census_q;
  assign valid_out  = valid_q;

`ifdef CENSUS_COORD_EN
  coord_t crow_q, crow_d, ccol_q, ccol_d;

  always_comb begin
    crow_d = win_full ? row_eff - coord_t'(1) : crow_q;
    ccol_d = win_full ? col_eff - coord_t'(1) : ccol_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crow_q <= '0;
      ccol_q <= '0;
    end else begin
      crow_q <= crow_d;
      ccol_q <= ccol_d;
    end
  end

  assign census_row = crow_q;
  assign census_col = ccol_q;
`endif

endmodule

// File: tb/tb_census_transform.sv
// tb_census_transform -- self-checking bench for census_transform (8x4 image).
module tb_census_transform;

  localparam int W = 8;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pixel_in;
  logic       valid_in;
  logic       sof_in;
  logic [7:0] census_out;
  logic       valid_out;
`ifdef CENSUS_COORD_EN
  logic [10:0] census_row, census_col;
  logic [10:0] exp_row_q[$];
  logic [10:0] exp_col_q[$];
`endif

  int         tests_run    = 0;
  int         tests_failed = 0;
  int         n_strobes    = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       exp_fire     = 1'b0;
  logic [7:0] exp_hold     = 8'h00;
  int         m_row        = 0;
  int         m_col        = 0;
  logic [7:0] pix [0:H-1][0:W-1];

  census_transform #(
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .PIXEL_WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pixel_in   (pixel_in),
    .valid_in   (valid_in),
    .sof_in     (sof_in),
    .census_out (census_out),
    .valid_out  (valid_out)
`ifdef CENSUS_COORD_EN
    ,
    .census_row (census_row),
    .census_col (census_col)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Census code of centre (r-1, c-1) once pixel (r, c) has been sent.
  function automatic logic [7:0] model_code(input int r, input int c);
    logic [7:0] code;
    logic [7:0] ctr;
    int k;
    code = 8'h00;
    ctr  = pix[r-1][c-1];
    k    = 7;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (!(dr == 0 && dc == 0)) begin
          code[k] = (pix[r-1+dr][c-1+dc] < ctr);
          k--;
        end
      end
    end
    return code;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_pixel(input logic [7:0] v, input logic sof);
    @(negedge clk);
    if (sof) begin
      m_row = 0;
      m_col = 0;
    end
    pixel_in = v;
    sof_in   = sof;
    valid_in = 1'b1;
    pix[m_row][m_col] = v;
    if (m_row >= 2 && m_col >= 2) begin
      exp_fire = 1'b1;
      exp_q.push_back(model_code(m_row, m_col));
`ifdef CENSUS_COORD_EN
      exp_row_q.push_back(11'(m_row - 1));
      exp_col_q.push_back(11'(m_col - 1));
`endif
    end else begin
      exp_fire = 1'b0;
    end
    m_col++;
    if (m_col == W) begin
      m_col = 0;
      m_row++;
      if (m_row == H) m_row = 0;
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    valid_in = 1'b0;
    sof_in   = 1'b0;
    pixel_in = 8'($urandom_range(0, 255));
    exp_fire = 1'b0;
  endtask

  // mode: 0 flat 0x80, 1 spot at (1,1), 2 ramp col*10, 3 random
  // gap:  0 none, 1 one idle after each pixel, 2 random 0..2 idles
  task automatic send_frame(input int mode, input int gap, input bit use_sof);
    logic [7:0] v;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        case (mode)
          0:       v = 8'h80;
          1:       v = (r == 1 && c == 1) ? 8'hFF : 8'h10;
          2:       v = 8'(c * 10);
          default: v = 8'($urandom_range(0, 255));
        endcase
        send_pixel(v, use_sof && r == 0 && c == 0);
        if (gap == 1) idle_cycle();
        if (gap == 2) repeat ($urandom_range(0, 2)) idle_cycle();
      end
    end
    repeat (2) idle_cycle();
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      tests_run++;
      if (valid_out !== exp_fire) begin
        tests_failed++;
        $display("FAIL strobe_timing @%0t: valid_out=%b want %b", $time, valid_out, exp_fire);
      end
      if (valid_out === 1'b1) begin
        n_strobes++;
        got_q.push_back(census_out);
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_strobe @%0t: census_out=%02h, none expected", $time, census_out);
        end else begin
          exp_hold = exp_q.pop_front();
          if (census_out !== exp_hold) begin
            tests_failed++;
            $display("FAIL census_code @%0t: got %02h want %02h", $time, census_out, exp_hold);
          end
`ifdef CENSUS_COORD_EN
          begin
            logic [10:0] er, ec;
            er = exp_row_q.pop_front();
            ec = exp_col_q.pop_front();
            tests_run++;
            if (census_row !== er || census_col !== ec) begin
              tests_failed++;
              $display("FAIL census_coord @%0t: got (%0d,%0d) want (%0d,%0d)",
                       $time, census_row, census_col, er, ec);
            end
          end
`endif
        end
      end else begin
        tests_run++;
        if (census_out !== exp_hold) begin
          tests_failed++;
          $display("FAIL census_hold @%0t: got %02h want %02h", $time, census_out, exp_hold);
        end
      end
    end
  end

  task automatic clear_counts();
    n_strobes = 0;
    got_q.delete();
  endtask

  task automatic check_frame_end(input string name, input int want_strobes);
    tests_run++;
    if (n_strobes != want_strobes || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_count: strobes=%0d want %0d, pending=%0d want 0",
               name, n_strobes, want_strobes, exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (census_out !== 8'h00 || valid_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: census_out=%02h valid_out=%b want 00/0", census_out, valid_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Part of a ramp frame so census_out is non-zero before the reset.
    for (int i = 0; i < 2 * W + 5; i++) send_pixel(8'((i % W) * 10), i == 0);
    repeat (2) idle_cycle();
    tests_run++;
    if (census_out !== 8'h94) begin
      tests_failed++;
      $display("FAIL pre_reset_code: got %02h want 94", census_out);
    end
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    exp_hold = 8'h00;
    m_row    = 0;
    m_col    = 0;
    #1;
    tests_run++;
    if (census_out !== 8'h00 || valid_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: census_out=%02h valid_out=%b want 00/0", census_out, valid_out);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (census_out !== 8'h00 || valid_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL in_reset: census_out=%02h valid_out=%b want 00/0", census_out, valid_out);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (census_out !== 8'h00 || valid_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_reset: census_out=%02h valid_out=%b want 00/0", census_out, valid_out);
    end
    // Frame after reset starts at (0,0) without sof_in.
    clear_counts();
    send_frame(2, 0, 1'b0);
    check_frame_end("reset_frame", (H - 2) * (W - 2));
  endtask

  task automatic test_flat();
    clear_counts();
    send_frame(0, 0, 1'b1);
    check_frame_end("flat", 12);
    foreach (got_q[i]) begin
      tests_run++;
      if (got_q[i] !== 8'h00) begin
        tests_failed++;
        $display("FAIL flat_code[%0d]: got %02h want 00", i, got_q[i]);
      end
    end
  endtask

  task automatic test_spot();
    clear_counts();
    send_frame(1, 0, 1'b1);
    check_frame_end("spot", 12);
    tests_run++;
    if (got_q.size() < 2 || got_q[0] !== 8'hFF || got_q[1] !== 8'h00) begin
      tests_failed++;
      $display("FAIL spot_codes: first two=%02h %02h want FF 00",
               (got_q.size() > 0) ? got_q[0] : 8'hxx, (got_q.size() > 1) ? got_q[1] : 8'hxx);
    end
  endtask

  task automatic test_ramp(input int gap, input string name);
    clear_counts();
    send_frame(2, gap, 1'b1);
    check_frame_end(name, 12);
    foreach (got_q[i]) begin
      tests_run++;
      if (got_q[i] !== 8'h94) begin
        tests_failed++;
        $display("FAIL %s_code[%0d]: got %02h want 94", name, i, got_q[i]);
      end
    end
  endtask

  task automatic test_sof();
    // Frame 1 up to row 2 col 4, then sof_in lands on what would be (2,5).
    for (int i = 0; i < 2 * W + 5; i++) send_pixel(8'($urandom_range(0, 255)), i == 0);
    idle_cycle();
    clear_counts();
    send_frame(3, 0, 1'b1);
    check_frame_end("sof", 12);
  endtask

  task automatic test_back_to_back();
    clear_counts();
    send_frame(3, 2, 1'b1);
    send_frame(3, 0, 1'b0);
    send_frame(3, 2, 1'b0);
    check_frame_end("back_to_back", 3 * 12);
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    sof_in   = 1'b0;
    pixel_in = 8'h00;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        pix[r][c] = 8'h00;
    test_reset();
    test_flat();
    test_spot();
    test_ramp(0, "ramp");
    test_ramp(1, "ramp_gaps");
    test_sof();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/census_transform.md
CENSUS_TRANSFORM -- requirements
Module: census_transform

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640, meaning pixels per line (range 4..2048).
REQ-002 SHALL have parameter IMG_HEIGHT, default 480, meaning lines per frame (range 3..2048).
REQ-003 SHALL have parameter PIXEL_WIDTH, default 8, meaning grey-level bits per pixel.
REQ-004 SHALL have clk  input  1  the single clock, all logic on its rising edge.
REQ-005 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have pixel_in  input  PIXEL_WIDTH  raster-order pixel.
REQ-007 SHALL have valid_in  input  1  pixel_in accepted on every clk edge where high.
REQ-008 SHALL have sof_in  input  1  qualified by valid_in; marks that pixel as row 0, col 0.
REQ-009 SHALL have census_out  output  8  registered 3x3 census code, same width as the consumer's census input.
REQ-010 SHALL have valid_out  output  1  one-cycle strobe per census_out.

Function
REQ-011 SHALL keep column counter (0..IMG_WIDTH-1) and row counter (0..IMG_HEIGHT-1), advanced only on accepted pixels.
REQ-012 Column SHALL wrap to 0 after IMG_WIDTH-1 and increment row; row SHALL wrap to 0 after IMG_HEIGHT-1 (next frame, no sof_in needed).
REQ-013 Accepted pixel with sof_in=1 SHALL be treated as row 0, col 0 regardless of counter state, counters continuing from there.
REQ-014 SHALL hold two line buffers of IMG_WIDTH pixels (rows r-1, r-2) plus a 3x3 window register shifted once per accepted pixel.
REQ-015 Census bit SHALL be 1 when neighbour < centre (unsigned, strict), 0 otherwise; equal gives 0.
REQ-016 Bit order SHALL be 7=top-left, 6=top, 5=top-right, 4=left, 3=right, 2=bottom-left, 1=bottom, 0=bottom-right.
REQ-017 Window is complete when accepted pixel is at row>=2 and col>=2; census centre is then (row-1, col-1).
REQ-018 valid_out SHALL assert exactly one clk after each such accepted pixel, census_out valid in that same cycle; latency fixed at 1.
REQ-019 No output SHALL be produced for border centres (row 0, row H-1, col 0, col W-1); exactly (IMG_HEIGHT-2)*(IMG_WIDTH-2) strobes per frame.
REQ-020 Window SHALL never mix pixels across line boundaries; column-0/1 pixels of a new line only prime the window.
REQ-021 valid_in low cycles SHALL freeze all state; valid_out low the following cycle; census_out holds last value.
REQ-022 No back-pressure: consumer SHALL accept every valid_out strobe.

Reset
REQ-023 On rst_n low: census_out=0, valid_out=0, counters=0, window registers=0, immediately and asynchronously.
REQ-024 Line-buffer contents need not be cleared; REQ-017 gating guarantees stale data never reaches census_out.
REQ-025 Reset mid-frame SHALL discard the frame; first input after release is row 0, col 0.

Configuration
REQ-026 Macro CENSUS_COORD_EN defined: SHALL add outputs census_row and census_col (each 11 bits) giving the centre coordinates of census_out, registered with it, reset 0.
REQ-027 CENSUS_COORD_EN undefined: those ports and their logic SHALL be absent; all other behaviour identical.

Structure
REQ-028 Package census_pkg SHALL hold CENSUS_WIDTH=8, WIN_SIZE=3, coordinate width 11 and bit-position constants of REQ-016.
REQ-029 Sub-module census_line_buffer SHALL implement one IMG_WIDTH x PIXEL_WIDTH delay line (read and write same address per accepted pixel), instantiated twice.

Verification
REQ-030 Reset: rst_n low for 3 cycles mid-stream -> census_out=0x00, valid_out=0 during reset and next cycle.
REQ-031 W=8,H=4, all pixels 0x80 -> exactly 12 strobes, all census_out=0x00.
REQ-032 W=8,H=4, pixel (1,1)=0xFF, others 0x10 -> code for centre (1,1)=0xFF, code for centre (1,2)=0x00.
REQ-033 W=8,H=4, pixel=col*10 -> all 12 codes = 0x94, each 1 cycle after the accepted pixel at (r+1,c+1).
REQ-034 REQ-033 stimulus with valid_in toggling every cycle -> identical 12-code sequence, no strobe in gap cycles.
REQ-035 sof_in asserted at row 2 col 5 of frame 1 -> no strobe until new row 2 col 2 accepted; then 12 correct codes.
